// File: rtl/fir_cmplx_decim_if.sv
// I/Q sample and result bundle for the complex decimating FIR.
// The slave side is the filter; the master side owns the input and output FIFOs.
interface fir_cmplx_decim_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] x_real_in;
    logic [DATA_WIDTH-1:0] x_imag_in;
    logic                  x_real_empty;
    logic                  x_imag_empty;
    logic                  x_real_rd_en;
    logic                  x_imag_rd_en;
    logic [DATA_WIDTH-1:0] y_real_out;
    logic [DATA_WIDTH-1:0] y_imag_out;
    logic                  y_real_full;
    logic                  y_imag_full;
    logic                  y_real_wr_en;
    logic                  y_imag_wr_en;

    modport master (
        output x_real_in, x_imag_in, x_real_empty, x_imag_empty,
        output y_real_full, y_imag_full,
        input  x_real_rd_en, x_imag_rd_en,
        input  y_real_out, y_imag_out, y_real_wr_en, y_imag_wr_en
    );

    modport slave (
        input  x_real_in, x_imag_in, x_real_empty, x_imag_empty,
        input  y_real_full, y_imag_full,
        output x_real_rd_en, x_imag_rd_en,
        output y_real_out, y_imag_out, y_real_wr_en, y_imag_wr_en
    );
endinterface

// File: rtl/fir_cmplx_decim.sv
// Complex-coefficient FIR with integer decimation: one time-shared complex MAC,
// one tap per cycle, one output written per DECIMATION accepted input samples.
module fir_cmplx_decim #(
    parameter int TAPS       = 20,
    parameter int DECIMATION = 1,
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int ACC_WIDTH  = 48,
    parameter logic [0:TAPS-1][COEF_WIDTH-1:0] H_REAL = '0,
    parameter logic [0:TAPS-1][COEF_WIDTH-1:0] H_IMAG = '0
) (
    input  logic               clk,
    input  logic               rst,
    fir_cmplx_decim_if.slave   bus
);
    localparam int TAP_W = $clog2(TAPS);
    localparam int PH_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int PW    = DATA_WIDTH + COEF_WIDTH;
    localparam int EW    = (PW > ACC_WIDTH) ? PW : ACC_WIDTH;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIMATION - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [TAP_W-1:0]      tap_q, tap_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [ACC_WIDTH-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic [DATA_WIDTH-1:0] y_r_q, y_r_d, y_i_q, y_i_d;
    logic [DATA_WIDTH-1:0] x_r_q [TAPS];
    logic [DATA_WIDTH-1:0] x_r_d [TAPS];
    logic [DATA_WIDTH-1:0] x_i_q [TAPS];
    logic [DATA_WIDTH-1:0] x_i_d [TAPS];

    logic                  rd_en, wr_en, shift_en;
    logic signed [DATA_WIDTH-1:0] xr_sel, xi_sel;
    logic signed [COEF_WIDTH-1:0] hr_sel, hi_sel;
    logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
    logic signed [EW-1:0]  t_rr, t_ii, t_ri, t_ir, pr_ext, pi_ext;

    // Tap products: each full-width product is floored by FRAC_BITS on its own
    // before the terms are combined, so the rounding matches a per-product model.
    always_comb begin
        xr_sel = x_r_q[tap_q];
        xi_sel = x_i_q[tap_q];
        hr_sel = H_REAL[tap_q];
        hi_sel = H_IMAG[tap_q];
        p_rr   = xr_sel * hr_sel;
        p_ii   = xi_sel * hi_sel;
        p_ri   = xr_sel * hi_sel;
        p_ir   = xi_sel * hr_sel;
        t_rr   = EW'(p_rr >>> FRAC_BITS);
        t_ii   = EW'(p_ii >>> FRAC_BITS);
        t_ri   = EW'(p_ri >>> FRAC_BITS);
        t_ir   = EW'(p_ir >>> FRAC_BITS);
        pr_ext = t_rr - t_ii;
        pi_ext = t_ri + t_ir;
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        phase_d  = phase_q;
        acc_r_d  = acc_r_q;
        acc_i_d  = acc_i_q;
        y_r_d    = y_r_q;
        y_i_d    = y_i_q;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (!bus.x_real_empty && !bus.x_imag_empty) begin
                    rd_en    = 1'b1;
                    shift_en = 1'b1;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        tap_d   = '0;
                        acc_r_d = '0;
                        acc_i_d = '0;
                        state_d = ST_MAC;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            ST_MAC: begin
                acc_r_d = acc_r_q + pr_ext[ACC_WIDTH-1:0];
                acc_i_d = acc_i_q + pi_ext[ACC_WIDTH-1:0];
                tap_d   = tap_q + TAP_W'(1);
                if (tap_q == TAP_LAST) begin
                    // Latch the truncated result once so it stays stable through any stall.
                    y_r_d   = acc_r_d[DATA_WIDTH-1:0];
                    y_i_d   = acc_i_d[DATA_WIDTH-1:0];
                    tap_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (!bus.y_real_full && !bus.y_imag_full) begin
                    wr_en   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            x_r_d[k] = x_r_q[k];
            x_i_d[k] = x_i_q[k];
        end
        if (shift_en) begin
            x_r_d[0] = bus.x_real_in;
            x_i_d[0] = bus.x_imag_in;
            for (int k = 1; k < TAPS; k++) begin
                x_r_d[k] = x_r_q[k-1];
                x_i_d[k] = x_i_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            tap_q   <= '0;
            phase_q <= '0;
            acc_r_q <= '0;
            acc_i_q <= '0;
            y_r_q   <= '0;
            y_i_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_r_q[k] <= '0;
                x_i_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            phase_q <= phase_d;
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
            y_r_q   <= y_r_d;
            y_i_q   <= y_i_d;
            for (int k = 0; k < TAPS; k++) begin
                x_r_q[k] <= x_r_d[k];
                x_i_q[k] <= x_i_d[k];
            end
        end
    end

    // Strobes are combinational so a pop/push lands on the same edge as the decision.
    assign bus.x_real_rd_en = rd_en && !rst;
    assign bus.x_imag_rd_en = rd_en && !rst;
    assign bus.y_real_wr_en = wr_en && !rst;
    assign bus.y_imag_wr_en = wr_en && !rst;
    assign bus.y_real_out   = y_r_q;
    assign bus.y_imag_out   = y_i_q;
endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Directed bench: four filter instances (ramp, h=j, decimate-by-2, half-LSB)
// driven through show-ahead FIFO handshakes with hand-computed results.
module tb_fir_cmplx_decim;
    localparam int N = 4;
    localparam int TAPS = 4;
    localparam logic [0:3][31:0] H_RAMP = {32'd1024, 32'd2048, 32'd3072, 32'd4096};
    localparam logic [0:3][31:0] H_ZERO = {32'd0, 32'd0, 32'd0, 32'd0};
    localparam logic [0:3][31:0] H_J    = {32'd1024, 32'd0, 32'd0, 32'd0};
    localparam logic [0:3][31:0] H_HALF = {32'd512, 32'd0, 32'd0, 32'd0};

    logic clk = 1'b0;
    logic rst;
    logic signed [31:0] x_r [N];
    logic signed [31:0] x_i [N];
    logic xr_e [N];
    logic xi_e [N];
    logic yr_f [N];
    logic yi_f [N];
    logic rd_r [N];
    logic rd_i [N];
    logic wr_r [N];
    logic wr_i [N];
    logic signed [31:0] y_r [N];
    logic signed [31:0] y_i [N];

    int tests_run = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam logic [0:3][31:0] HR = (gi == 1) ? H_ZERO : ((gi == 3) ? H_HALF : H_RAMP);
        localparam logic [0:3][31:0] HI = (gi == 1) ? H_J : H_ZERO;
        localparam int DEC = (gi == 2) ? 2 : 1;

        fir_cmplx_decim_if #(.DATA_WIDTH(32)) u_if ();

        assign u_if.x_real_in    = x_r[gi];
        assign u_if.x_imag_in    = x_i[gi];
        assign u_if.x_real_empty = xr_e[gi];
        assign u_if.x_imag_empty = xi_e[gi];
        assign u_if.y_real_full  = yr_f[gi];
        assign u_if.y_imag_full  = yi_f[gi];
        assign rd_r[gi] = u_if.x_real_rd_en;
        assign rd_i[gi] = u_if.x_imag_rd_en;
        assign wr_r[gi] = u_if.y_real_wr_en;
        assign wr_i[gi] = u_if.y_imag_wr_en;
        assign y_r[gi]  = u_if.y_real_out;
        assign y_i[gi]  = u_if.y_imag_out;

        fir_cmplx_decim #(
            .TAPS(TAPS), .DECIMATION(DEC), .DATA_WIDTH(32), .COEF_WIDTH(32),
            .FRAC_BITS(10), .ACC_WIDTH(48), .H_REAL(HR), .H_IMAG(HI)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    // Offer one sample on instance d and wait (bounded) for it to be popped.
    task automatic push(input int d, input logic signed [31:0] r, input logic signed [31:0] im,
                        input string tag);
        bit seen = 1'b0;
        bit both = 1'b0;
        x_r[d] = r; x_i[d] = im; xr_e[d] = 1'b0; xi_e[d] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (rd_r[d]) begin
                seen = 1'b1;
                both = rd_i[d];
                break;
            end
            @(negedge clk);
        end
        if (seen) begin
            @(posedge clk);
            @(negedge clk);
        end
        xr_e[d] = 1'b1; xi_e[d] = 1'b1;
        tests_run++;
        if (!seen || !both) begin
            failed++;
            $display("FAIL %s read: rd_real=%0d rd_imag=%0d, required both 1", tag, seen, both);
        end
    endtask

    // Release backpressure on instance d and check the next write.
    task automatic pop(input int d, input logic signed [31:0] er, input logic signed [31:0] ei,
                       input int exp_lat, input string tag);
        bit seen = 1'b0;
        bit both = 1'b0;
        int lat = 1;
        logic signed [31:0] gr, gi_v;
        gr = '0; gi_v = '0;
        yr_f[d] = 1'b0; yi_f[d] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (wr_r[d]) begin
                seen = 1'b1; both = wr_i[d]; gr = y_r[d]; gi_v = y_i[d];
                break;
            end
            lat++;
            @(negedge clk);
        end
        if (seen) begin
            @(posedge clk);
            @(negedge clk);
        end
        yr_f[d] = 1'b1; yi_f[d] = 1'b1;
        tests_run++;
        if (!seen || !both) begin
            failed++;
            $display("FAIL %s write: wr_real=%0d wr_imag=%0d, required both 1", tag, seen, both);
        end
        tests_run++;
        if (gr !== er) begin
            failed++;
            $display("FAIL %s y_real: got %0d expected %0d", tag, gr, er);
        end
        tests_run++;
        if (gi_v !== ei) begin
            failed++;
            $display("FAIL %s y_imag: got %0d expected %0d", tag, gi_v, ei);
        end
        if (exp_lat >= 0) begin
            tests_run++;
            if (lat != exp_lat) begin
                failed++;
                $display("FAIL %s latency: got %0d cycles expected %0d", tag, lat, exp_lat);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            x_r[d] = 32'sd77; x_i[d] = 32'sd77;
            xr_e[d] = 1'b0; xi_e[d] = 1'b0; yr_f[d] = 1'b0; yi_f[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            tests_run++;
            if (rd_r[d] !== 1'b0 || rd_i[d] !== 1'b0 || wr_r[d] !== 1'b0 || wr_i[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset_strobes[%0d]: rd=%b/%b wr=%b/%b expected all 0",
                         d, rd_r[d], rd_i[d], wr_r[d], wr_i[d]);
            end
            tests_run++;
            if (y_r[d] !== 32'sd0 || y_i[d] !== 32'sd0) begin
                failed++;
                $display("FAIL reset_y[%0d]: got (%0d,%0d) expected (0,0)", d, y_r[d], y_i[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            xr_e[d] = 1'b1; xi_e[d] = 1'b1; yr_f[d] = 1'b1; yi_f[d] = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        logic signed [31:0] exp_r [4];
        exp_r = '{32'sd2048, 32'sd3072, 32'sd4096, 32'sd0};
        push(0, 32'sd1024, 32'sd0, "impulse0");
        pop(0, 32'sd1024, 32'sd0, TAPS + 1, "impulse0");
        for (int k = 0; k < 4; k++) begin
            push(0, 32'sd0, 32'sd0, "impulse");
            pop(0, exp_r[k], 32'sd0, -1, $sformatf("impulse%0d", k + 1));
        end
    endtask

    task automatic test_complex_mult();
        push(1, 32'sd1024, 32'sd2048, "cmult");
        pop(1, -32'sd2048, 32'sd1024, TAPS + 1, "cmult");
    endtask

    task automatic test_decimation();
        logic signed [31:0] exp_r [3];
        exp_r = '{32'sd2048, 32'sd4096, 32'sd0};
        for (int k = 0; k < 3; k++) begin
            push(2, (k == 0) ? 32'sd1024 : 32'sd0, 32'sd0, "decim_a");
            push(2, 32'sd0, 32'sd0, "decim_b");
            pop(2, exp_r[k], 32'sd0, TAPS + 1, $sformatf("decim_n%0d", 2 * k + 1));
        end
    endtask

    task automatic test_rounding();
        push(3, -32'sd1, 32'sd0, "floor");
        pop(3, -32'sd1, 32'sd0, -1, "floor");
    endtask

    task automatic test_backpressure();
        push(0, 32'sd1024, 32'sd0, "bp");
        yr_f[0] = 1'b1; yi_f[0] = 1'b0;
        repeat (5) @(negedge clk);
        x_r[0] = 32'sd555; x_i[0] = 32'sd555; xr_e[0] = 1'b0; xi_e[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            tests_run++;
            if (wr_r[0] !== 1'b0 || wr_i[0] !== 1'b0 || rd_r[0] !== 1'b0 || rd_i[0] !== 1'b0) begin
                failed++;
                $display("FAIL bp_strobes cycle %0d: wr=%b/%b rd=%b/%b expected all 0",
                         c, wr_r[0], wr_i[0], rd_r[0], rd_i[0]);
            end
            tests_run++;
            if (y_r[0] !== 32'sd1024 || y_i[0] !== 32'sd0) begin
                failed++;
                $display("FAIL bp_hold cycle %0d: got (%0d,%0d) expected (1024,0)", c, y_r[0], y_i[0]);
            end
            @(negedge clk);
        end
        xr_e[0] = 1'b1; xi_e[0] = 1'b1;
        pop(0, 32'sd1024, 32'sd0, -1, "bp_release");
    endtask

    task automatic test_empty_skew();
        x_r[0] = 32'sd2048; x_i[0] = 32'sd0;
        for (int c = 0; c < 12; c++) begin
            xr_e[0] = (c >= 8); xi_e[0] = (c < 8);
            #1;
            tests_run++;
            if (rd_r[0] !== 1'b0 || rd_i[0] !== 1'b0) begin
                failed++;
                $display("FAIL skew cycle %0d: rd=%b/%b expected 0/0", c, rd_r[0], rd_i[0]);
            end
            @(negedge clk);
        end
        push(0, 32'sd2048, 32'sd0, "skew");
        pop(0, 32'sd4096, 32'sd0, -1, "skew");
    endtask

    task automatic test_reset_mid_mac();
        push(0, 32'sd1024, 32'sd0, "midrst");
        @(negedge clk);
        rst = 1'b1; yr_f[0] = 1'b0; yi_f[0] = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (y_r[0] !== 32'sd0 || wr_r[0] !== 1'b0) begin
            failed++;
            $display("FAIL midrst_clear: y=%0d wr=%b expected 0/0", y_r[0], wr_r[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            tests_run++;
            if (wr_r[0] !== 1'b0) begin
                failed++;
                $display("FAIL midrst_nowrite cycle %0d: wr=%b expected 0", c, wr_r[0]);
            end
            @(negedge clk);
        end
        yr_f[0] = 1'b1; yi_f[0] = 1'b1;
        push(0, 32'sd1024, 32'sd0, "midrst_a");
        pop(0, 32'sd1024, 32'sd0, -1, "midrst_hist0");
        push(0, 32'sd0, 32'sd0, "midrst_b");
        pop(0, 32'sd2048, 32'sd0, -1, "midrst_hist1");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_complex_mult();
        test_decimation();
        test_rounding();
        test_backpressure();
        test_empty_skew();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
